// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared definitions for the unified-memory arbiter: the access sequencer
// state encoding, the requester IDs used for grant and last-grant, and the
// width of the memory latency down-counter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_e;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DMA = 1'b1;

  // Wide enough for MEM_LAT-1 with MEM_LAT up to 15
  localparam int CNT_W = 4;

endpackage

// File: rtl/arb_rr2.sv
// arb_rr2
// Two-way round-robin pick. With a single requester that requester wins;
// with both requesting, the one that was not granted last wins.
// Ports:
//   req_i  - request vector, bit REQ_CPU = CPU, bit REQ_DMA = loader
//   last_i - ID of the requester granted most recently
//   gnt_o  - ID of the winning requester (only meaningful when req_i != 0)
module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       gnt_o
);

  // Default to the CPU; the loader wins when it is alone or when the CPU
  // was served last during a conflict.
  always_comb begin
    gnt_o = REQ_CPU;
    if (req_i == 2'b11) begin
      gnt_o = ~last_i;
    end else if (req_i[REQ_DMA]) begin
      gnt_o = REQ_DMA;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Arbitrates the CPU and the loader onto the single unified memory. A
// granted request is latched, issued to memory for one cycle, waits out the
// fixed memory latency, captures read data and pulses the requester's done.
// Ports:
//   clk, rst                         - clock, asynchronous active-low reset
//   c_req/c_we/c_adr/c_wdata         - CPU request (level, held until c_done)
//   c_done/c_rdata/cpu_stall         - CPU completion, read data, stall
//   d_req/d_we/d_adr/d_wdata         - loader request
//   d_done/d_rdata                   - loader completion, read data
//   m_en/m_we/m_adr/m_wdata/m_rdata  - memory side
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT = 2,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_adr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_done,
  output logic [DW-1:0] c_rdata,
  output logic          cpu_stall,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_adr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_done,
  output logic [DW-1:0] d_rdata,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_adr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata
);

  state_e             state_q;
  logic               gnt_q;
  logic               lastGnt_q;
  logic               we_q;
  logic [AW-1:0]      adr_q;
  logic [DW-1:0]      wdata_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [DW-1:0]      cRdata_q;
  logic [DW-1:0]      dRdata_q;
  logic               cDone_q;
  logic               dDone_q;
  logic               mEn_q;
  logic               mWe_q;

  logic               pick_d;
  logic               selWe_d;
  logic [AW-1:0]      selAdr_d;
  logic [DW-1:0]      selWdata_d;

  arb_rr2 u_rr (
    .req_i  ({d_req, c_req}),
    .last_i (lastGnt_q),
    .gnt_o  (pick_d)
  );

  // Fields of whichever port the round-robin pick selects this cycle
  always_comb begin
    selWe_d    = c_we;
    selAdr_d   = c_adr;
    selWdata_d = c_wdata;
    if (pick_d == REQ_DMA) begin
      selWe_d    = d_we;
      selAdr_d   = d_adr;
      selWdata_d = d_wdata;
    end
  end

  // Access sequencer. All outputs except cpu_stall are registered here so
  // that the async reset clears them immediately. Requests are only looked
  // at in IDLE, so the requester inputs are free to change once latched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      gnt_q     <= REQ_CPU;
      lastGnt_q <= REQ_DMA;
      we_q      <= 1'b0;
      adr_q     <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      cRdata_q  <= '0;
      dRdata_q  <= '0;
      cDone_q   <= 1'b0;
      dDone_q   <= 1'b0;
      mEn_q     <= 1'b0;
      mWe_q     <= 1'b0;
    end else begin
      cDone_q <= 1'b0;
      dDone_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (c_req || d_req) begin
            state_q <= ISSUE;
            gnt_q   <= pick_d;
            we_q    <= selWe_d;
            adr_q   <= selAdr_d;
            wdata_q <= selWdata_d;
            mEn_q   <= 1'b1;
            mWe_q   <= selWe_d;
          end
        end
        ISSUE: begin
          state_q <= WAIT;
          mEn_q   <= 1'b0;
          mWe_q   <= 1'b0;
          cnt_q   <= CNT_W'(MEM_LAT - 1);
        end
        WAIT: begin
          if (cnt_q == '0) begin
            if (!we_q) begin
              if (gnt_q == REQ_DMA) begin
                dRdata_q <= m_rdata;
              end else begin
                cRdata_q <= m_rdata;
              end
            end
            if (gnt_q == REQ_DMA) begin
              dDone_q <= 1'b1;
            end else begin
              cDone_q <= 1'b1;
            end
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          lastGnt_q <= gnt_q;
          state_q   <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign c_done    = cDone_q;
  assign d_done    = dDone_q;
  assign c_rdata   = cRdata_q;
  assign d_rdata   = dRdata_q;
  assign m_en      = mEn_q;
  assign m_we      = mWe_q;
  assign m_adr     = adr_q;
  assign m_wdata   = wdata_q;
  assign cpu_stall = c_req & ~cDone_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Drives the CPU and loader ports of mem_arbiter, plays the memory, and
// compares everything the arbiter presents against expectations derived
// from the arbitration and timing rules: an access granted in the first
// free IDLE cycle g shows m_en in g+1, data valid in g+1+LAT, done in
// g+2+LAT, and the arbiter is free again in g+LAT+3.
module tb_mem_arbiter;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        cReq, cWe, dReq, dWe;
  logic [31:0] cAdr, cWdata, dAdr, dWdata;
  logic        cDone, dDone, cpuStall, mEn, mWe;
  logic [31:0] cRdata, dRdata, mAdr, mWdata, mRdata;

  int          checkCount = 0;
  int          failCount  = 0;
  int          cyc        = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_LAT(LAT), .AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .c_req(cReq), .c_we(cWe), .c_adr(cAdr), .c_wdata(cWdata),
    .c_done(cDone), .c_rdata(cRdata), .cpu_stall(cpuStall),
    .d_req(dReq), .d_we(dWe), .d_adr(dAdr), .d_wdata(dWdata),
    .d_done(dDone), .d_rdata(dRdata),
    .m_en(mEn), .m_we(mWe), .m_adr(mAdr), .m_wdata(mWdata), .m_rdata(mRdata)
  );

  // Latency-sweep instances share a simple CPU-only stimulus
  logic        sReq = 1'b0;
  int          sStart = -100;
  logic        l1CDone, l1Stall, l1DDone, l1MEn, l1MWe;
  logic [31:0] l1CRdata, l1DRdata, l1MAdr, l1MWdata, l1MRdata;
  logic        l15CDone, l15Stall, l15DDone, l15MEn, l15MWe;
  logic [31:0] l15CRdata, l15DRdata, l15MAdr, l15MWdata, l15MRdata;

  assign l1MRdata  = (cyc == sStart + 2)  ? 32'h0001_5A5A : 32'hDEAD_0001;
  assign l15MRdata = (cyc == sStart + 16) ? 32'h000F_5A5A : 32'hDEAD_000F;

  mem_arbiter #(.MEM_LAT(1), .AW(32), .DW(32)) dutLat1 (
    .clk(clk), .rst(rst),
    .c_req(sReq), .c_we(1'b0), .c_adr(32'h0000_0010), .c_wdata(32'h0),
    .c_done(l1CDone), .c_rdata(l1CRdata), .cpu_stall(l1Stall),
    .d_req(1'b0), .d_we(1'b0), .d_adr(32'h0), .d_wdata(32'h0),
    .d_done(l1DDone), .d_rdata(l1DRdata),
    .m_en(l1MEn), .m_we(l1MWe), .m_adr(l1MAdr), .m_wdata(l1MWdata),
    .m_rdata(l1MRdata)
  );

  mem_arbiter #(.MEM_LAT(15), .AW(32), .DW(32)) dutLat15 (
    .clk(clk), .rst(rst),
    .c_req(sReq), .c_we(1'b0), .c_adr(32'h0000_0010), .c_wdata(32'h0),
    .c_done(l15CDone), .c_rdata(l15CRdata), .cpu_stall(l15Stall),
    .d_req(1'b0), .d_we(1'b0), .d_adr(32'h0), .d_wdata(32'h0),
    .d_done(l15DDone), .d_rdata(l15DRdata),
    .m_en(l15MEn), .m_we(l15MWe), .m_adr(l15MAdr), .m_wdata(l15MWdata),
    .m_rdata(l15MRdata)
  );

  // Memory model: data is only valid in the single cycle LAT cycles after
  // the m_en cycle; every other cycle carries recognisable junk.
  logic [31:0] mem    [256];
  logic [31:0] shadow [256];
  int          pendCycle = -100;
  logic [7:0]  pendIdx   = 8'h0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mEn) begin
      pendCycle <= cyc + LAT;
      pendIdx   <= mAdr[9:2];
      if (mWe) mem[mAdr[9:2]] <= mWdata;
    end
  end

  assign mRdata = (cyc == pendCycle) ? mem[pendIdx] : {cyc[15:0], 16'hBADD};

  // Scoreboard state
  typedef struct {
    int          cyc;
    logic        we;
    logic [31:0] adr;
    logic [31:0] wdata;
  } issue_t;

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
  } done_t;

  issue_t      issueQ[$];
  done_t       cQ[$];
  done_t       dQ[$];
  int          freeCycle = 0;
  logic        lastG = 1'b1;
  logic [31:0] cHeld = 32'h0, dHeld = 32'h0, cNext = 32'h0, dNext = 32'h0;
  int          actFrom = 0, actTo = -1;
  logic [31:0] actAdr = 32'h0, actWdata = 32'h0;

  task automatic checkOutput(input string name, input logic [127:0] act,
                             input logic [127:0] exp);
    checkCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: whenever the arbiter is free and someone is asking,
  // decide the winner round-robin and predict the whole access.
  logic        selW;
  logic [31:0] selA, selWd, selRd;
  logic        win;

  always @(negedge clk) begin
    if (rst && (cyc >= freeCycle) && (cReq || dReq)) begin
      win = (cReq && dReq) ? ~lastG : dReq;
      lastG = win;
      if (win) begin
        selW = dWe; selA = dAdr; selWd = dWdata;
      end else begin
        selW = cWe; selA = cAdr; selWd = cWdata;
      end
      selRd = shadow[selA[9:2]];
      if (selW) shadow[selA[9:2]] = selWd;
      issueQ.push_back('{cyc + 1, selW, selA, selWd});
      if (win) begin
        if (!selW) dNext = selRd;
        dQ.push_back('{cyc + 2 + LAT, dNext});
      end else begin
        if (!selW) cNext = selRd;
        cQ.push_back('{cyc + 2 + LAT, cNext});
      end
      actFrom   = cyc + 1;
      actTo     = cyc + 1 + LAT;
      actAdr    = selA;
      actWdata  = selWd;
      freeCycle = cyc + LAT + 3;
    end
  end

  // Monitor: pops predictions whenever the DUT shows m_en or a done, and
  // checks held read data, bus stability and the stall every cycle.
  issue_t ie;
  done_t  de;
  logic   cExp;

  always @(negedge clk) begin
    if (rst) begin
      if (mEn) begin
        if (issueQ.size() == 0) begin
          checkOutput("m_en_unexpected", 128'(mEn), 128'(1'b0));
        end else begin
          ie = issueQ.pop_front();
          checkOutput("m_access", 128'({cyc, mWe, mAdr, mWdata}),
                      128'({ie.cyc, ie.we, ie.adr, ie.wdata}));
        end
      end
      while (issueQ.size() > 0 && issueQ[0].cyc < cyc) begin
        ie = issueQ.pop_front();
        checkOutput("m_en_missing", 128'(cyc), 128'(ie.cyc));
      end
      if (cyc >= actFrom && cyc <= actTo)
        checkOutput("m_bus_stable", 128'({mAdr, mWdata}), 128'({actAdr, actWdata}));

      cExp = (cQ.size() > 0) && (cQ[0].cyc == cyc);
      checkOutput("cpu_stall", 128'(cpuStall), 128'(cReq && !cExp));

      if (cDone) begin
        if (cQ.size() == 0) begin
          checkOutput("c_done_unexpected", 128'(cDone), 128'(1'b0));
        end else begin
          de = cQ.pop_front();
          cHeld = de.rdata;
          checkOutput("c_done_read", 128'({cyc, cRdata}), 128'({de.cyc, de.rdata}));
        end
      end
      while (cQ.size() > 0 && cQ[0].cyc < cyc) begin
        de = cQ.pop_front();
        cHeld = de.rdata;
        checkOutput("c_done_missing", 128'(cyc), 128'(de.cyc));
      end
      checkOutput("c_rdata_hold", 128'(cRdata), 128'(cHeld));

      if (dDone) begin
        if (dQ.size() == 0) begin
          checkOutput("d_done_unexpected", 128'(dDone), 128'(1'b0));
        end else begin
          de = dQ.pop_front();
          dHeld = de.rdata;
          checkOutput("d_done_read", 128'({cyc, dRdata}), 128'({de.cyc, de.rdata}));
        end
      end
      while (dQ.size() > 0 && dQ[0].cyc < cyc) begin
        de = dQ.pop_front();
        dHeld = de.rdata;
        checkOutput("d_done_missing", 128'(cyc), 128'(de.cyc));
      end
      checkOutput("d_rdata_hold", 128'(dRdata), 128'(dHeld));
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic assertReset();
    rst = 1'b0;
    issueQ.delete();
    cQ.delete();
    dQ.delete();
    lastG = 1'b1;
    cHeld = 32'h0; dHeld = 32'h0; cNext = 32'h0; dNext = 32'h0;
    actFrom = 0; actTo = -1;
  endtask

  task automatic releaseReset();
    freeCycle = cyc;
    rst = 1'b1;
  endtask

  // Raise a request on one port, hold it until its done, drop it in the
  // following cycle (the caller may re-raise it immediately).
  task automatic applyStimulus(input logic port, input logic we,
                               input logic [31:0] adr, input logic [31:0] wdata);
    logic seen;
    if (port) begin
      dReq = 1'b1; dWe = we; dAdr = adr; dWdata = wdata;
    end else begin
      cReq = 1'b1; cWe = we; cAdr = adr; cWdata = wdata;
    end
    seen = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      seen = port ? dDone : cDone;
    end
    if (!seen)
      checkOutput(port ? "d_done_timeout" : "c_done_timeout",
                  128'(port ? dDone : cDone), 128'(1'b1));
    @(posedge clk);
    #1;
    if (port) dReq = 1'b0;
    else      cReq = 1'b0;
  endtask

  task automatic randomTraffic(input logic port, input int count);
    for (int i = 0; i < count; i++) begin
      waitCycles($urandom_range(0, 3));
      applyStimulus(port, 1'($urandom_range(0, 1)),
                    32'($urandom_range(0, 15)) << 2, $urandom);
    end
  endtask

  int d1, d15;
  logic [31:0] r1, r15;

  initial begin
    cReq = 0; cWe = 0; cAdr = 0; cWdata = 0;
    dReq = 0; dWe = 0; dAdr = 0; dWdata = 0;
    for (int i = 0; i < 256; i++) begin
      mem[i]    = (32'(i) * 32'h0101_0101) ^ 32'hC0DE_0000;
      shadow[i] = (32'(i) * 32'h0101_0101) ^ 32'hC0DE_0000;
    end
    mem[4]    = 32'h2402_0005;
    shadow[4] = 32'h2402_0005;

    #2;
    assertReset();
    waitCycles(3);
    checkOutput("reset_ctrl", 128'({cDone, dDone, cpuStall, mEn, mWe, dRdata}), 128'(0));
    checkOutput("reset_bus", 128'({mAdr, mWdata, cRdata}), 128'(0));
    releaseReset();

    // CPU read of 0x10, then loader write of 0xDEADBEEF to 0x40
    applyStimulus(1'b0, 1'b0, 32'h0000_0010, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF);

    // Address change while the access is in flight must be ignored
    fork
      applyStimulus(1'b0, 1'b0, 32'h0000_0010, 32'h0);
      begin
        waitCycles(2);
        cAdr = 32'h0000_0020;
      end
    join

    // Simultaneous requests straight after reset: CPU first, then loader
    assertReset();
    waitCycles(2);
    releaseReset();
    fork
      applyStimulus(1'b0, 1'b0, 32'h0000_0010, 32'h0);
      applyStimulus(1'b1, 1'b0, 32'h0000_0040, 32'h0);
    join
    fork
      repeat (3) applyStimulus(1'b0, 1'b1, 32'h0000_0008, $urandom);
      repeat (3) applyStimulus(1'b1, 1'b0, 32'h0000_0008, 32'h0);
    join

    // Reset in the middle of a read
    cReq = 1'b1; cWe = 1'b0; cAdr = 32'h0000_0010;
    waitCycles(1);
    checkOutput("abort_m_en_before", 128'(mEn), 128'(1'b1));
    #1;
    assertReset();
    #1;
    checkOutput("abort_ctrl", 128'({cDone, dDone, mEn, mWe, cpuStall}), 128'(5'b00001));
    checkOutput("abort_bus", 128'({mAdr, mWdata, cRdata}), 128'(0));
    waitCycles(2);
    cReq = 1'b0;
    releaseReset();
    applyStimulus(1'b0, 1'b0, 32'h0000_0010, 32'h0);

    // Randomised traffic from both ports
    fork
      randomTraffic(1'b0, 30);
      randomTraffic(1'b1, 30);
    join

    // Latency sweep on the MEM_LAT=1 and MEM_LAT=15 instances
    d1 = -1; d15 = -1; r1 = 32'h0; r15 = 32'h0;
    sStart = cyc;
    sReq = 1'b1;
    for (int n = 0; n < 40 && (d1 < 0 || d15 < 0); n++) begin
      @(negedge clk);
      if (l1CDone && d1 < 0) begin
        d1 = cyc - sStart; r1 = l1CRdata;
      end
      if (l15CDone && d15 < 0) begin
        d15 = cyc - sStart; r15 = l15CRdata;
      end
    end
    waitCycles(1);
    sReq = 1'b0;
    checkOutput("lat1_done", 128'({d1, r1}), 128'({32'd3, 32'h0001_5A5A}));
    checkOutput("lat15_done", 128'({d15, r15}), 128'({32'd17, 32'h000F_5A5A}));

    waitCycles(LAT + 5);
    checkOutput("queues_drained", 128'(issueQ.size() + cQ.size() + dQ.size()), 128'(0));

    $display("test done: total=%0d bad=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port memory arbiter and access sequencer placed between the multicycle CPU, a program/data loader (DMA) and the single unified instruction/data memory. Each requester issues a level request and holds it until a one-cycle done pulse. The arbiter latches the request, drives the memory for one issue cycle, waits a fixed memory latency, returns read data and signals completion. It also produces the CPU stall signal that the CPU controller uses to freeze its state machine during memory states.

## Interface
- MEM_LAT, 2, memory read latency in cycles from the m_en cycle to valid m_rdata; legal range 1..15
- AW, 32, address width
- DW, 32, data width

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- c_req  in  1  CPU request; level, held until c_done
- c_we  in  1  CPU write (1) / read (0)
- c_adr  in  AW  CPU byte address
- c_wdata  in  DW  CPU write data
- c_done  out  1  one-cycle CPU completion pulse
- c_rdata  out  DW  CPU read data; valid in the c_done cycle and held until the next CPU completion
- cpu_stall  out  1  c_req & ~c_done (combinational)
- d_req, d_we, d_adr, d_wdata  in  1/1/AW/DW  loader request; same rules as the CPU port
- d_done  out  1  loader completion pulse
- d_rdata  out  DW  loader read data; same rules as c_rdata
- m_en  out  1  memory access strobe, exactly one cycle per access
- m_we  out  1  memory write, qualified by m_en
- m_adr  out  AW  memory address
- m_wdata  out  DW  memory write data
- m_rdata  in  DW  memory read data

## Operation
- FSM states and transitions:
  - IDLE → ISSUE on any request.
  - ISSUE → WAIT after one cycle.
  - WAIT → DONE after MEM_LAT cycles.
  - DONE → IDLE after one cycle.
- Grant is decided in IDLE.
  - One request pending: grant it.
  - Both pending: grant the requester not granted last (round-robin).
  - last_grant resets to loader, so the CPU wins the first conflict.
- On IDLE→ISSUE, latch gnt, we, adr and wdata of the granted port. Later changes on the requester inputs are ignored until DONE.
- ISSUE: m_en=1 and m_we=latched we. m_adr and m_wdata are driven from the latches and held stable through WAIT.
- WAIT: a 4-bit down-counter loads MEM_LAT-1 on entry. At the end of the cycle where the count is 0:
  - read: capture m_rdata into the granted port's rdata register;
  - write: rdata is unchanged.
- DONE: pulse the granted port's done output, update last_grant, return to IDLE.
- Requests are not sampled in DONE. A requester still asserting req in the cycle after its done starts a new access.
- Writes take the same sequence and latency as reads.

## Timing
- Reset values: all outputs 0, both rdata registers 0, FSM=IDLE, counter=0, last_grant=loader.
- Request first seen high in IDLE at cycle 0:
  - m_en in cycle 1;
  - m_rdata sampled at the end of cycle 1+MEM_LAT;
  - done in cycle 2+MEM_LAT.
  - With MEM_LAT=2: done in cycle 4; the next grant is evaluated at the earliest in cycle 5.
- Throughput: one access per MEM_LAT+3 cycles.
- A request arriving during a non-IDLE state waits. Its latency counts from the first IDLE cycle.
- Reset mid-access: FSM returns to IDLE immediately and m_en drops asynchronously. No done is produced for the aborted access; requesters must reissue.
- Simultaneous requests: resolved in the same IDLE cycle. The loser is served on the very next IDLE.

## Structure
- Package mem_arb_pkg holds:
  - state enum (IDLE, ISSUE, WAIT, DONE);
  - requester ID constants (REQ_CPU=0, REQ_DMA=1);
  - latency-counter width constant.
- Sub-module arb_rr2: a combinational two-way round-robin pick (req[1:0], last → gnt). Everything else is inline in mem_arbiter.

## Test plan
- CPU read only: MEM_LAT=2, c_req@0, adr 0x0000_0010, memory returns 0x2402_0005 in cycle 3 → m_en only in cycle 1 with m_adr 0x10; c_done and c_rdata=0x2402_0005 in cycle 4; cpu_stall high in cycles 0-3.
- Loader write: d_req@0, d_we=1, adr 0x40, wdata 0xDEAD_BEEF → m_en=m_we=1 in cycle 1 with that adr/data; d_done in cycle 4; d_rdata unchanged.
- Conflict: both req@0 after reset → CPU granted first (c_done cycle 4). Loader m_en in cycle 6, d_done in cycle 9. Repeated with both held high, grants alternate.
- Input change: c_adr changed from 0x10 to 0x20 in cycle 2 → m_adr stays 0x10 through cycle 3.
- Reset abort: rst low in cycle 2 of a read → outputs 0 at once, no c_done. After release and reissue, the full MEM_LAT+2 latency is observed.
- Latency sweep: MEM_LAT=1 and 15 → done in cycles 3 and 17 respectively.
